// File: rtl/dcache_wb_param.sv
// dcache_wb_param: parametrised write-back, write-allocate data cache with an
// MMIO bypass window and 1- or 2-way LRU associativity.
// Optional feature: define DCACHE_STATS_EN to build the miss/total counters;
// without it both outputs are tied to zero.
module dcache_wb_param #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_2000,
    parameter logic [7:0]  MMIO_TAG   = 8'h7f,
    parameter int          LINE_WORDS = 4,
    parameter int          SETS       = 64,
    parameter int          WAYS       = 2,
    parameter int          MEM_AW     = 10
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rstn,
    input  logic                     cvalid,
    input  logic                     cpu_req_rw,
    input  logic [31:0]              a,
    input  logic [31:0]              d,
    output logic [31:0]              spo,
    output logic                     cready,
    output logic                     mmio,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic                     mem_req_rw,
    output logic                     mvalid,
    output logic [32*LINE_WORDS-1:0] din,
    input  logic [32*LINE_WORDS-1:0] dout,
    input  logic                     mready,
    output logic [31:0]              miss,
    output logic [31:0]              total
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = MEM_AW - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WB,
        S_GAP,
        S_REFILL
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request, held from acceptance until cready.
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rw;
    logic        r_victim;

    // Per-way state and storage.
    logic [SETS-1:0]  r_valid [WAYS];
    logic [SETS-1:0]  r_dirty [WAYS];
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];

    logic [31:0]      w_rel;
    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_hit_way;
    logic             w_victim;
    logic             w_accept;
    logic             w_unused;

    // Address split of the latched request; bits above the line address and
    // the byte offset are intentionally ignored.
    assign w_rel    = r_addr - ADDR_BASE;
    assign w_off    = w_rel[2 +: OFF_W];
    assign w_idx    = w_rel[2 + OFF_W +: IDX_W];
    assign w_tag    = w_rel[2 + OFF_W + IDX_W +: TAG_W];
    assign w_unused = ^w_rel;

    assign mmio     = cvalid && (a[15:8] == MMIO_TAG);
    assign w_accept = (r_state == S_IDLE) && cvalid && !mmio;

    // Tag lookup across all ways of the addressed set.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 1'(w);
            end
        end
    end

    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] r_lru;

            // Point the per-set LRU bit at the way not used by the latest hit.
            always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
                if (!cpu_rstn) begin
                    r_lru <= '0;
                end else if ((r_state == S_COMPARE) && w_hit) begin
                    r_lru[w_idx] <= ~w_hit_way;
                end
            end

            // Victim: first invalid way (way 0 preferred), otherwise the LRU way.
            assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                              !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
        end else begin : g_dm
            assign w_victim = 1'b0;
        end
    endgenerate

    // State register, request latch and valid/dirty bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rw     <= 1'b0;
            r_victim <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= a;
                r_wdata <= d;
                r_rw    <= cpu_req_rw;
            end
            if (r_state == S_COMPARE) begin
                if (w_hit) begin
                    if (r_rw) begin
                        r_dirty[w_hit_way][w_idx] <= 1'b1;
                    end
                end else begin
                    r_victim <= w_victim;
                end
            end
            if ((r_state == S_REFILL) && mready) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
        end
    end

    // Tag and line storage: write hits update one word, refills load a line.
    // NOTE: the storage arrays have no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge cpu_clk) begin
        if ((r_state == S_COMPARE) && w_hit && r_rw) begin
            r_data[w_hit_way][w_idx][w_off] <= r_wdata;
        end
        if ((r_state == S_REFILL) && mready) begin
            r_tag[r_victim][w_idx] <= w_tag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_data[r_victim][w_idx][i] <= dout[32*i +: 32];
            end
        end
    end

    // Next-state logic and the CPU/memory outputs decoded from the state.
    always_comb begin
        w_next     = r_state;
        spo        = '0;
        cready     = 1'b0;
        mvalid     = 1'b0;
        mem_req_rw = 1'b0;
        mem_addr   = '0;
        din        = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    cready = 1'b1;
                    if (!r_rw) begin
                        spo = r_data[w_hit_way][w_idx][w_off];
                    end
                    w_next = S_IDLE;
                end else if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_REFILL;
                end
            end
            S_WB: begin
                mvalid     = 1'b1;
                mem_req_rw = 1'b1;
                mem_addr   = {r_tag[r_victim][w_idx], w_idx};
                for (int i = 0; i < LINE_WORDS; i++) begin
                    din[32*i +: 32] = r_data[r_victim][w_idx][i];
                end
                if (mready) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_REFILL;
            end
            S_REFILL: begin
                mvalid   = 1'b1;
                mem_addr = {w_tag, w_idx};
                if (mready) begin
                    w_next = S_COMPARE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_miss;
    logic [31:0] r_total;

    // Count accepted requests and first-pass misses; both wrap naturally.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_miss  <= '0;
            r_total <= '0;
        end else begin
            if (w_accept) begin
                r_total <= r_total + 32'd1;
            end
            if ((r_state == S_COMPARE) && !w_hit) begin
                r_miss <= r_miss + 32'd1;
            end
        end
    end

    assign miss  = r_miss;
    assign total = r_total;
`else
    assign miss  = '0;
    assign total = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_param.sv
// tb_dcache_wb_param: directed plus randomized bench for dcache_wb_param.
// The reference keeps resident lines per set with recency stamps and a flat
// copy of backing memory; a line-level responder answers memory requests.
module tb_dcache_wb_param;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int LW    = 4;
    localparam int SETS  = 64;
    localparam int LINES = 1024;

    typedef struct packed {
        logic         rw;
        logic [9:0]   addr;
        logic [127:0] data;
    } mreq_t;

    logic         cpu_clk    = 1'b0;
    logic         cpu_rstn   = 1'b1;
    logic         cvalid     = 1'b0;
    logic         cpu_req_rw = 1'b0;
    logic [31:0]  a          = '0;
    logic [31:0]  d          = '0;
    logic [31:0]  spo;
    logic         cready;
    logic         mmio;
    logic [9:0]   mem_addr;
    logic         mem_req_rw;
    logic         mvalid;
    logic [127:0] din;
    logic [127:0] dout       = '0;
    logic         mready     = 1'b0;
    logic [31:0]  miss;
    logic [31:0]  total;

    dcache_wb_param dut (
        .cpu_clk    (cpu_clk),
        .cpu_rstn   (cpu_rstn),
        .cvalid     (cvalid),
        .cpu_req_rw (cpu_req_rw),
        .a          (a),
        .d          (d),
        .spo        (spo),
        .cready     (cready),
        .mmio       (mmio),
        .mem_addr   (mem_addr),
        .mem_req_rw (mem_req_rw),
        .mvalid     (mvalid),
        .din        (din),
        .dout       (dout),
        .mready     (mready),
        .miss       (miss),
        .total      (total)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT did not respond within the cycle budget at %0t", name, $time);
        finish_run();
    endtask

    // ---------------- memory responder ----------------
    logic [127:0] mem     [LINES];
    logic [127:0] ref_mem [LINES];
    mreq_t        mem_log [$];
    int           rsp_cnt = 0;

    // mready rises in the third cycle of mvalid (two cycles after it rises).
    always @(negedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rsp_cnt = 0;
            mready  = 1'b0;
        end else if (mvalid && !mready) begin
            rsp_cnt++;
            if (rsp_cnt == 3) begin
                rsp_cnt = 0;
                mready  = 1'b1;
                mem_log.push_back({mem_req_rw, mem_addr, din});
                if (mem_req_rw) mem[mem_addr] = din;
                else            dout = mem[mem_addr];
            end
        end else begin
            mready  = 1'b0;
            rsp_cnt = 0;
        end
    end

    // ---------------- reference model ----------------
    bit           m_valid [SETS][2];
    bit           m_dirty [SETS][2];
    int unsigned  m_tag   [SETS][2];
    int unsigned  m_age   [SETS][2];
    logic [31:0]  m_data  [SETS][2][LW];
    int unsigned  m_clock = 0;
    mreq_t        exp_log [$];
    int           exp_miss  = 0;
    int           exp_total = 0;
    bit           mem_ok    = 1'b0;

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model_access(input logic [31:0] addr, input bit rw, input logic [31:0] wd,
                                output logic [31:0] rdata, output bit was_miss, output bit was_dirty);
        int unsigned  word;
        int unsigned  off;
        int unsigned  line;
        int unsigned  set;
        int unsigned  tg;
        int unsigned  vline;
        int           slot;
        logic [127:0] vl;
        word = (addr - 32'h2000) >> 2;
        off  = word % LW;
        line = (word / LW) % LINES;
        set  = line % SETS;
        tg   = line / SETS;
        slot = -1;
        exp_log.delete();
        was_dirty = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (m_valid[set][s] && m_tag[set][s] == tg) slot = s;
        end
        was_miss = (slot < 0);
        if (slot < 0) begin
            if (!m_valid[set][0])      slot = 0;
            else if (!m_valid[set][1]) slot = 1;
            else                       slot = (m_age[set][0] < m_age[set][1]) ? 0 : 1;
            if (m_valid[set][slot] && m_dirty[set][slot]) begin
                for (int k = 0; k < LW; k++) vl[32*k +: 32] = m_data[set][slot][k];
                vline          = m_tag[set][slot] * SETS + set;
                ref_mem[vline] = vl;
                exp_log.push_back({1'b1, 10'(vline), vl});
                was_dirty = 1'b1;
            end
            exp_log.push_back({1'b0, 10'(line), 128'h0});
            m_valid[set][slot] = 1'b1;
            m_dirty[set][slot] = 1'b0;
            m_tag[set][slot]   = tg;
            for (int k = 0; k < LW; k++) m_data[set][slot][k] = ref_mem[line][32*k +: 32];
        end
        m_clock++;
        m_age[set][slot] = m_clock;
        if (rw) begin
            m_data[set][slot][off] = wd;
            m_dirty[set][slot]     = 1'b1;
            rdata = '0;
        end else begin
            rdata = m_data[set][slot][off];
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int wb_gap = 0;

    always begin
        @(negedge cpu_clk);
        #1;
        if (cpu_rstn) begin
            check("mmio", mmio, cvalid && (a[15:8] == 8'h7f));
            check("total", total, STATS ? exp_total : 0);
            check("miss", miss, STATS ? exp_miss : 0);
            if (!cready) check("spo_quiet", spo, 0);
            if (!mvalid) begin
                check("mem_addr_quiet", mem_addr, 0);
                check("din_quiet", din, 0);
            end else if (!mem_req_rw) begin
                check("din_refill", din, 0);
            end
            if (!mem_ok) check("mvalid_quiet", mvalid, 0);
            if (wb_gap == 1) begin
                check("gap_cycle", mvalid, 0);
                wb_gap = 2;
            end else if (wb_gap == 2) begin
                check("refill_after_gap", {mvalid, mem_req_rw}, 2'b10);
                wb_gap = 0;
            end
            if (mvalid && mem_req_rw && mready) wb_gap = 1;
        end else begin
            wb_gap = 0;
        end
    end

    // ---------------- request driver ----------------
    logic [31:0] last_spo;
    int          last_lat;

    task automatic do_req(input logic [31:0] addr, input bit rw, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          mis;
        bit          drt;
        int          n;
        int          lat;
        model_access(addr, rw, wd, exp_rd, mis, drt);
        lat = !mis ? 1 : (drt ? 9 : 5);
        mem_log.delete();
        mem_ok = mis;
        @(negedge cpu_clk);
        a          = addr;
        d          = wd;
        cpu_req_rw = rw;
        cvalid     = 1'b1;
        @(posedge cpu_clk);
        exp_total++;
        n = 0;
        while (1) begin
            @(negedge cpu_clk);
            n++;
            if (cready) break;
            if (n >= 40) fail_now("cready_timeout");
            if (n == 1 && mis) begin
                @(posedge cpu_clk);
                exp_miss++;
            end
        end
        last_spo = spo;
        last_lat = n;
        check("latency", n, lat);
        check("spo", spo, exp_rd);
        cvalid = 1'b0;
        mem_ok = 1'b0;
        check("memlog_len", mem_log.size(), exp_log.size());
        for (int i = 0; i < mem_log.size() && i < exp_log.size(); i++) begin
            check("memlog_entry", mem_log[i], exp_log[i]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mreq_t       e;
        int          n;
        int          set_sel;
        int unsigned set;
        int unsigned tg;
        int unsigned off;
        logic [31:0] addr;

        for (int i = 0; i < LINES; i++) begin
            for (int k = 0; k < LW; k++) mem[i][32*k +: 32] = 32'(i * LW + k + 1);
            ref_mem[i] = mem[i];
        end
        model_clear();

        #1 cpu_rstn = 1'b0;
        #2;
        check("rst_spo", spo, 0);
        check("rst_cready", cready, 0);
        check("rst_mvalid", mvalid, 0);
        check("rst_mem_req_rw", mem_req_rw, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_din", din, 0);
        check("rst_miss", miss, 0);
        check("rst_total", total, 0);
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;

        // Cold read of line 0.
        do_req(32'h2000, 1'b0, 32'h0);
        check("p1_spo", last_spo, 32'd1);
        e = mem_log[0];
        check("p1_refill", {e.rw, e.addr}, 11'h000);
        check("p1_miss", miss, STATS ? 1 : 0);
        check("p1_total", total, STATS ? 1 : 0);

        // Hit on the same line.
        do_req(32'h2004, 1'b0, 32'h0);
        check("p2_spo", last_spo, 32'd2);
        check("p2_lat", last_lat, 1);
        check("p2_nomem", mem_log.size(), 0);
        check("p2_total", total, STATS ? 2 : 0);

        // Write hit then read back.
        do_req(32'h2008, 1'b1, 32'hDEAD_BEEF);
        check("p3_nomem", mem_log.size(), 0);
        do_req(32'h2008, 1'b0, 32'h0);
        check("p3_spo", last_spo, 32'hDEAD_BEEF);

        // Second way of set 0, then a conflicting line evicts dirty way 0.
        do_req(32'h2400, 1'b0, 32'h0);
        e = mem_log[0];
        check("p4_refill", e.addr, 10'd64);
        check("p4_spo", last_spo, 32'h101);
        do_req(32'h2800, 1'b0, 32'h0);
        check("p5_memlen", mem_log.size(), 2);
        e = mem_log[0];
        check("p5_wb", {e.rw, e.addr}, {1'b1, 10'd0});
        check("p5_wb_word2", e.data[95:64], 32'hDEAD_BEEF);
        e = mem_log[1];
        check("p5_refill", {e.rw, e.addr}, {1'b0, 10'd128});
        check("p5_lat", last_lat, 9);
        check("p5_miss", miss, STATS ? 3 : 0);

        // MMIO window is ignored.
        @(negedge cpu_clk);
        a      = 32'h7F00;
        cvalid = 1'b1;
        repeat (5) begin
            @(negedge cpu_clk);
            check("mmio_cready", cready, 0);
        end
        cvalid = 1'b0;

        // Reset while a refill is outstanding.
        mem_log.delete();
        mem_ok = 1'b1;
        @(negedge cpu_clk);
        a          = 32'h2010;
        cpu_req_rw = 1'b0;
        cvalid     = 1'b1;
        @(posedge cpu_clk);
        exp_total++;
        @(posedge cpu_clk);
        exp_miss++;
        n = 0;
        while (!mvalid) begin
            @(negedge cpu_clk);
            n++;
            if (n >= 20) fail_now("refill_start_timeout");
        end
        @(negedge cpu_clk);
        #2;
        cpu_rstn  = 1'b0;
        cvalid    = 1'b0;
        exp_total = 0;
        exp_miss  = 0;
        mem_ok    = 1'b0;
        model_clear();
        #1;
        check("midrst_mvalid", mvalid, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_cready", cready, 0);
        check("midrst_miss", miss, 0);
        check("midrst_total", total, 0);
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        do_req(32'h2004, 1'b0, 32'h0);
        check("post_rst_lat", last_lat, 5);
        check("post_rst_spo", last_spo, 32'd2);
        check("post_rst_miss", miss, STATS ? 1 : 0);
        check("post_rst_total", total, STATS ? 1 : 0);

        // Randomized traffic concentrated on three sets to force conflicts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) begin
                n = $urandom_range(3, 1);
                @(negedge cpu_clk);
                a          = {16'h0000, 8'h7f, 8'($urandom)};
                cpu_req_rw = 1'($urandom_range(1));
                cvalid     = 1'b1;
                repeat (n) begin
                    @(negedge cpu_clk);
                    check("rand_mmio_cready", cready, 0);
                end
                cvalid = 1'b0;
            end else begin
                set_sel = $urandom_range(2);
                set     = (set_sel == 0) ? 0 : (set_sel == 1) ? 1 : 63;
                tg      = $urandom_range(3);
                off     = $urandom_range(3);
                addr    = 32'h2000 + 32'(((tg * SETS + set) * LW + off) * 4);
                do_req(addr, 1'($urandom_range(1)), $urandom);
            end
        end

        repeat (2) @(negedge cpu_clk);
        finish_run();
    end

endmodule

// File: doc/dcache_wb_param.md
# dcache_wb_param

Parametrised write-back, write-allocate data cache with MMIO bypass window and optional hit/miss statistics. Sits between the CPU data port and the line-wide backing data memory. Generalises the fixed direct-mapped data-memory subsystem to configurable line size, set count and associativity (1 or 2 ways with LRU replacement).

## Interface

Parameters:
- `ADDR_BASE`, 32'h00002000: subtracted from `a` before indexing.
- `MMIO_TAG`, 8'h7f: `a[15:8]` value marking an MMIO access; such accesses bypass the cache.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `SETS`, 64: sets per way; power of two.
- `WAYS`, 2: 1 (direct-mapped) or 2 (LRU).
- `MEM_AW`, 10: backing-memory line-address width; must exceed log2(`SETS`).

Ports:
- `cpu_clk` in 1: clock.
- `cpu_rstn` in 1: asynchronous active-low reset.
- `cvalid` in 1: CPU request valid.
- `cpu_req_rw` in 1: 1 = write, 0 = read.
- `a` in 32: byte address.
- `d` in 32: write data.
- `spo` out 32: read data.
- `cready` out 1: request complete (one cycle).
- `mmio` out 1: combinational `cvalid && a[15:8]==MMIO_TAG`.
- `mem_addr` out `MEM_AW`: line address to memory.
- `mem_req_rw` out 1: 1 = write line, 0 = read line.
- `mvalid` out 1: memory request valid.
- `din` out 32·`LINE_WORDS`: line to memory.
- `dout` in 32·`LINE_WORDS`: line from memory.
- `mready` in 1: memory transfer done.
- `miss` out 32: miss count.
- `total` out 32: access count.

## Operation

- Address split:
  - word = (`a`−`ADDR_BASE`)>>2.
  - offset = low log2(`LINE_WORDS`) bits of word.
  - line = low `MEM_AW` bits of word>>log2(`LINE_WORDS`).
  - index = low log2(`SETS`) bits of line; tag = remaining bits of line.
- Per way, per set: valid, dirty, tag and line storage. Per set: one LRU bit when `WAYS`=2.
- FSM states: IDLE, COMPARE, WB, GAP, REFILL.
- IDLE: on `cvalid && !mmio`, latch `a`, `d`, `cpu_req_rw` and go to COMPARE. MMIO requests are ignored: no state change, `cready` stays 0, not counted.
- COMPARE, hit:
  - Assert `cready`. Read: `spo` = addressed word. Write: update word, set dirty.
  - Set LRU to point at the other way. Go to IDLE.
- COMPARE, miss: choose victim (first invalid way, way 0 preferred; else LRU way). Victim dirty → WB; otherwise → REFILL.
- WB: `mvalid`=1, `mem_req_rw`=1, `mem_addr`={victim tag, index}, `din`=victim line. On `mready` → GAP.
- GAP: `mvalid`=0 for one cycle → REFILL.
- REFILL: `mvalid`=1, `mem_req_rw`=0, `mem_addr`={tag, index}. On `mready`, write `dout` into the victim way, set valid=1, dirty=0, load tag, → COMPARE. This COMPARE hits and is not counted as a miss.
- Outside a read hit in COMPARE, `spo`=0. `mvalid`=0 outside WB/REFILL. `din`=0 outside WB.
- Requester holds `cvalid`/`a`/`d` stable until `cready`, then must drop or change them.

## Timing

- Reset values: state IDLE; all valid, dirty and LRU bits 0; `spo`, `cready`, `mvalid`, `mem_req_rw`, `mem_addr`, `din`, `miss`, `total` all 0. `mmio` is combinational.
- Hit: request sampled at edge E0; `cready` high in the cycle after E0. Next request is accepted at the edge after the `cready` cycle, giving one IDLE bubble.
- Clean miss: `cready` in the cycle after the `mready` cycle.
- Dirty miss: WB, then one GAP cycle, then REFILL.
- `mvalid` holds until `mready` is sampled. `mready` outside WB/REFILL is ignored.
- Reset mid-operation (any state): outputs return to reset values asynchronously and all lines are invalidated. Dirty data is lost and no writeback is issued.

## Configuration

- `DCACHE_STATS_EN` defined:
  - `total` +1 on each accepted non-MMIO request.
  - `miss` +1 on each first-pass COMPARE miss.
  - Both wrap modulo 2^32.
- `DCACHE_STATS_EN` undefined: counters are absent; `miss` and `total` are constant 0.

## Test plan

Default parameters, stats enabled, backing memory responds with `mready` 2 cycles after `mvalid`.

- Reset; read 0x2000 with memory line 0 = {4,3,2,1} (word0=1):
  - REFILL with `mem_addr`=0; `spo`=1 with `cready`.
  - `miss`=1, `total`=1.
- Then read 0x2004: `cready` 1 cycle after acceptance, `spo`=2, no `mvalid`; `miss`=1, `total`=2.
- Write 0x2008 `d`=0xDEADBEEF (hit): no memory traffic. Read 0x2008 returns 0xDEADBEEF.
- Read 0x2400 (set 0, way 1 refill, `mem_addr`=64), then read 0x2800:
  - Evicts way 0: WB with `mem_addr`=0 and `din` word2=0xDEADBEEF.
  - One GAP cycle with `mvalid`=0, then REFILL with `mem_addr`=128.
  - `miss`=3.
- `a`=0x7F00, `cvalid`=1 for 5 cycles: `mmio`=1, `cready`=0, `mvalid`=0, `total` unchanged.
- Assert `cpu_rstn`=0 while REFILL waits:
  - `mvalid`=0 immediately.
  - After release, read 0x2004 misses; `miss`=1, `total`=1.
- Build without `DCACHE_STATS_EN`, repeat the first scenario: `miss`=`total`=0 throughout.
